// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler
//
// Dual-issue scheduler placed between decode and the even/odd execution pipes.
// Decode hands over one instruction pair per handshake. The scheduler routes
// each slot to its pipe. A slot is held back when one of these applies:
//   - a structural conflict (both slots target the same pipe),
//   - a RAW or WAW hazard against the 128-entry latency scoreboard,
//   - an intra-pair dependency, or
//   - in-order issue (slot 1 never issues ahead of slot 0).
// A taken branch flushes the pending pair.
//
// Ports
//   clock, reset          rising-edge clock; synchronous active-low reset
//   in_valid / in_ready   pair handshake with decode (accept = both high)
//   sN_*                  slot N fields (N=0 older, N=1 younger):
//                           vld, pipe (0 even / 1 odd), rt, wr,
//                           ra/rb/rc, use {ra,rb,rc}, lat (1..7), pl
//   branch_taken          flush request: suppresses issue, clears the buffer
//   ep_* / op_*           issue strobe, payload and destination per pipe
//                           (payload and destination are zero when not issuing)
//   stall_cycles          saturating count of cycles with work pending and nothing issued
module dual_issue_scheduler #(
  parameter int PW = 32,
  parameter int LW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          s0_vld,
  input  logic          s0_pipe,
  input  logic [6:0]    s0_rt,
  input  logic          s0_wr,
  input  logic [6:0]    s0_ra,
  input  logic [6:0]    s0_rb,
  input  logic [6:0]    s0_rc,
  input  logic [2:0]    s0_use,
  input  logic [LW-1:0] s0_lat,
  input  logic [PW-1:0] s0_pl,
  input  logic          s1_vld,
  input  logic          s1_pipe,
  input  logic [6:0]    s1_rt,
  input  logic          s1_wr,
  input  logic [6:0]    s1_ra,
  input  logic [6:0]    s1_rb,
  input  logic [6:0]    s1_rc,
  input  logic [2:0]    s1_use,
  input  logic [LW-1:0] s1_lat,
  input  logic [PW-1:0] s1_pl,
  input  logic          branch_taken,
  output logic          ep_valid,
  output logic [PW-1:0] ep_pl,
  output logic [6:0]    ep_rt,
  output logic          op_valid,
  output logic [PW-1:0] op_pl,
  output logic [6:0]    op_rt,
  output logic [15:0]   stall_cycles
);

  localparam int            NREG    = 128;
  localparam logic [LW-1:0] LAT_ONE = LW'(1);

  typedef struct packed {
    logic          pipe;
    logic [6:0]    rt;
    logic          wr;
    logic [6:0]    ra;
    logic [6:0]    rb;
    logic [6:0]    rc;
    logic [2:0]    src_use;   // {ra, rb, rc}
    logic [LW-1:0] lat;
    logic [PW-1:0] pl;
  } slot_t;

  // EMPTY: nothing pending. PAIR: both slots pending. SECOND: only buf1 pending.
  typedef enum logic [1:0] {EMPTY, PAIR, SECOND} state_t;

  state_t        state, state_next;
  slot_t         in_slot0, in_slot1;
  slot_t         buf0, buf1;
  logic [LW-1:0] sb [NREG];   // cycles until each register is forwardable

  logic          accept;
  logic          pend0, pend1;
  logic          ok0, ok1, hold1;
  logic          issue0, issue1;
  logic          stall_inc;
  logic [LW-1:0] e0_ra, e0_rb, e0_rc, e0_rt;
  logic [LW-1:0] e1_ra, e1_rb, e1_rc, e1_rt;

  assign in_slot0 = '{pipe: s0_pipe, rt: s0_rt, wr: s0_wr, ra: s0_ra, rb: s0_rb,
                      rc: s0_rc, src_use: s0_use, lat: s0_lat, pl: s0_pl};
  assign in_slot1 = '{pipe: s1_pipe, rt: s1_rt, wr: s1_wr, ra: s1_ra, rb: s1_rb,
                      rc: s1_rc, src_use: s1_use, lat: s1_lat, pl: s1_pl};

  // RAW: every used source is forwardable now.
  // WAW: an in-flight write to rt retires no later than this one would.
  function automatic logic slot_ok(input slot_t s, input logic [LW-1:0] ea,
                                   input logic [LW-1:0] eb, input logic [LW-1:0] ec,
                                   input logic [LW-1:0] et);
    logic raw, waw;
    raw = !(s.src_use[2] && ea != '0) &&
          !(s.src_use[1] && eb != '0) &&
          !(s.src_use[0] && ec != '0);
    waw = !s.wr || (et <= s.lat - LAT_ONE);
    return raw && waw;
  endfunction

  function automatic logic touches_rt(input slot_t s, input logic [6:0] r);
    return (s.src_use[2] && s.ra == r) || (s.src_use[1] && s.rb == r) ||
           (s.src_use[0] && s.rc == r) || (s.wr && s.rt == r);
  endfunction

  assign e0_ra = sb[buf0.ra];
  assign e0_rb = sb[buf0.rb];
  assign e0_rc = sb[buf0.rc];
  assign e0_rt = sb[buf0.rt];
  assign e1_ra = sb[buf1.ra];
  assign e1_rb = sb[buf1.rb];
  assign e1_rc = sb[buf1.rc];
  assign e1_rt = sb[buf1.rt];

  assign pend0 = (state == PAIR);
  assign pend1 = (state != EMPTY);
  assign ok0   = slot_ok(buf0, e0_ra, e0_rb, e0_rc, e0_rt);
  assign ok1   = slot_ok(buf1, e1_ra, e1_rb, e1_rc, e1_rt);

  // While slot 0 is still pending, slot 1 cannot share its pipe or depend on its rt.
  // This also guarantees that the two slots never load the same scoreboard entry together.
  assign hold1  = pend0 && ((buf0.pipe == buf1.pipe) || (buf0.wr && touches_rt(buf1, buf0.rt)));
  assign issue0 = pend0 && ok0 && !branch_taken;
  assign issue1 = pend1 && ok1 && !branch_taken && !hold1 && (!pend0 || issue0);

  // Slot 1 issuing implies that everything pending drains this cycle.
  assign in_ready  = !branch_taken && ((state == EMPTY) || issue1);
  assign accept    = in_valid && in_ready;
  assign stall_inc = (state != EMPTY) && !issue0 && !issue1 && !branch_taken &&
                     (stall_cycles != 16'hFFFF);

  // NOTE: every variable written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      PAIR:    if (issue1) state_next = EMPTY; else if (issue0) state_next = SECOND;
      SECOND:  if (issue1) state_next = EMPTY;
      default: state_next = state;
    endcase
    if (accept) begin
      if (s0_vld && s1_vld)      state_next = PAIR;
      else if (s0_vld || s1_vld) state_next = SECOND;
      else                       state_next = EMPTY;
    end
    if (branch_taken) state_next = EMPTY;
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples the
  // values from before the edge, whatever the statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= EMPTY;
      stall_cycles <= '0;
    end else begin
      state <= state_next;
      if (stall_inc) stall_cycles <= stall_cycles + 16'd1;
    end
  end

  // A lone instruction always sits in buf1 (state SECOND), whichever slot it came from.
  // It then has no older partner to wait for, which matches its semantics.
  // NOTE: the slot buffer has no reset. Its contents are only observed through
  // pend0/pend1, and those come from the reset state.
  always_ff @(posedge clock) begin
    if (accept) begin
      buf0 <= in_slot0;
      buf1 <= s1_vld ? in_slot1 : in_slot0;
    end
  end

  // A load from an issuing writer follows the decrement, so it takes priority.
  // The scoreboard keeps counting through a flush, because in-flight results still retire.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) sb[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (sb[i] != '0) sb[i] <= sb[i] - LAT_ONE;
      end
      if (issue0 && buf0.wr) sb[buf0.rt] <= buf0.lat - LAT_ONE;
      if (issue1 && buf1.wr) sb[buf1.rt] <= buf1.lat - LAT_ONE;
    end
  end

  // The two issuing slots always target different pipes, so the assignments never collide.
  always_comb begin
    ep_valid = 1'b0;
    ep_pl    = '0;
    ep_rt    = '0;
    op_valid = 1'b0;
    op_pl    = '0;
    op_rt    = '0;
    if (issue0) begin
      if (buf0.pipe) begin op_valid = 1'b1; op_pl = buf0.pl; op_rt = buf0.rt; end
      else           begin ep_valid = 1'b1; ep_pl = buf0.pl; ep_rt = buf0.rt; end
    end
    if (issue1) begin
      if (buf1.pipe) begin op_valid = 1'b1; op_pl = buf1.pl; op_rt = buf1.rt; end
      else           begin ep_valid = 1'b1; ep_pl = buf1.pl; ep_rt = buf1.rt; end
    end
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb_dual_issue_scheduler
//
// Self-checking bench for dual_issue_scheduler, in three parts:
//   - a cycle table of directed vectors,
//   - hand-written multi-cycle corner sequences,
//   - a randomized run checked against a reference model. The model keeps
//     absolute "ready cycle" times per register and a queue of pending slots.
module tb_dual_issue_scheduler;

  localparam logic [31:0] PLB = 32'hA500_0000;

  typedef struct {
    bit        vld;
    bit        pipe;
    bit [6:0]  rt;
    bit        wr;
    bit [6:0]  ra;
    bit [6:0]  rb;
    bit [6:0]  rc;
    bit [2:0]  use_bits;
    bit [2:0]  lat;
    bit [31:0] pl;
  } slot_t;

  typedef struct {
    bit        iv;
    bit        bt;
    slot_t     s0;
    slot_t     s1;
    bit        rdy;
    bit        ev;
    bit [6:0]  ert;
    bit        ov;
    bit [6:0]  ort;
    bit [15:0] stall;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, branch_taken;
  logic        s0_vld, s0_pipe, s0_wr, s1_vld, s1_pipe, s1_wr;
  logic [6:0]  s0_rt, s0_ra, s0_rb, s0_rc, s1_rt, s1_ra, s1_rb, s1_rc;
  logic [2:0]  s0_use, s1_use, s0_lat, s1_lat;
  logic [31:0] s0_pl, s1_pl;
  logic        ep_valid, op_valid;
  logic [31:0] ep_pl, op_pl;
  logic [6:0]  ep_rt, op_rt;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  dual_issue_scheduler #(.PW(32), .LW(3)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .s0_vld(s0_vld), .s0_pipe(s0_pipe), .s0_rt(s0_rt), .s0_wr(s0_wr),
    .s0_ra(s0_ra), .s0_rb(s0_rb), .s0_rc(s0_rc), .s0_use(s0_use),
    .s0_lat(s0_lat), .s0_pl(s0_pl),
    .s1_vld(s1_vld), .s1_pipe(s1_pipe), .s1_rt(s1_rt), .s1_wr(s1_wr),
    .s1_ra(s1_ra), .s1_rb(s1_rb), .s1_rc(s1_rc), .s1_use(s1_use),
    .s1_lat(s1_lat), .s1_pl(s1_pl),
    .branch_taken(branch_taken),
    .ep_valid(ep_valid), .ep_pl(ep_pl), .ep_rt(ep_rt),
    .op_valid(op_valid), .op_pl(op_pl), .op_rt(op_rt),
    .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic slot_t mk(input bit pipe, input bit [6:0] rt, input bit wr,
                               input bit [2:0] lat, input bit [6:0] ra, input bit [2:0] u);
    slot_t s;
    s.vld = 1'b1; s.pipe = pipe; s.rt = rt; s.wr = wr; s.ra = ra; s.rb = 7'd0;
    s.rc = 7'd0; s.use_bits = u; s.lat = lat; s.pl = PLB | {25'd0, rt};
    return s;
  endfunction

  function automatic slot_t none();
    slot_t s;
    s = mk(1'b0, 7'd0, 1'b0, 3'd1, 7'd0, 3'b000);
    s.vld = 1'b0;
    return s;
  endfunction

  function automatic vec_t row(input bit iv, input slot_t a, input slot_t b, input bit rdy,
                               input bit ev, input bit [6:0] ert, input bit ov,
                               input bit [6:0] ort, input bit [15:0] stall);
    vec_t v;
    v.iv = iv; v.bt = 1'b0; v.s0 = a; v.s1 = b; v.rdy = rdy;
    v.ev = ev; v.ert = ert; v.ov = ov; v.ort = ort; v.stall = stall;
    return v;
  endfunction

  task automatic drive(input bit iv, input bit bt, input slot_t a, input slot_t b);
    in_valid = iv; branch_taken = bt;
    s0_vld = a.vld; s0_pipe = a.pipe; s0_rt = a.rt; s0_wr = a.wr; s0_ra = a.ra;
    s0_rb = a.rb; s0_rc = a.rc; s0_use = a.use_bits; s0_lat = a.lat; s0_pl = a.pl;
    s1_vld = b.vld; s1_pipe = b.pipe; s1_rt = b.rt; s1_wr = b.wr; s1_ra = b.ra;
    s1_rb = b.rb; s1_rc = b.rc; s1_use = b.use_bits; s1_lat = b.lat; s1_pl = b.pl;
  endtask

  // Drive this cycle's inputs and move to the falling edge, where outputs are sampled.
  task automatic step(input bit iv, input bit bt, input slot_t a, input slot_t b);
    drive(iv, bt, a, b);
    @(negedge clock);
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input bit rdy, input bit ev, input bit [6:0] ert,
                            input bit ov, input bit [6:0] ort);
    check({tag, ".in_ready"}, in_ready, rdy);
    check({tag, ".ep_valid"}, ep_valid, ev);
    check({tag, ".ep_rt"}, ep_rt, ev ? ert : 7'd0);
    check({tag, ".ep_pl"}, ep_pl, ev ? (PLB | {25'd0, ert}) : 32'd0);
    check({tag, ".op_valid"}, op_valid, ov);
    check({tag, ".op_rt"}, op_rt, ov ? ort : 7'd0);
    check({tag, ".op_pl"}, op_pl, ov ? (PLB | {25'd0, ort}) : 32'd0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, none(), none());
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // rdy[r] is the absolute cycle from which register r can be forwarded.
  // mq holds the pending instructions, oldest first.
  int    now;
  int    rdy [128];
  slot_t mq[$];
  int    m_stall;
  bit    m_iss0, m_iss1, m_ready;
  bit    x_ev, x_ov;
  bit [6:0]  x_ert, x_ort;
  bit [31:0] x_epl, x_opl;

  function automatic bit m_can_go(input slot_t s);
    if (s.use_bits[2] && rdy[s.ra] > now) return 1'b0;
    if (s.use_bits[1] && rdy[s.rb] > now) return 1'b0;
    if (s.use_bits[0] && rdy[s.rc] > now) return 1'b0;
    // The new write must not finish before the in-flight one to the same register.
    if (s.wr && rdy[s.rt] > now + int'(s.lat) - 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_uses(input slot_t s, input bit [6:0] r);
    return (s.use_bits[2] && s.ra == r) || (s.use_bits[1] && s.rb == r) ||
           (s.use_bits[0] && s.rc == r) || (s.wr && s.rt == r);
  endfunction

  task automatic m_reset();
    now = 0; m_stall = 0; mq.delete();
    for (int r = 0; r < 128; r++) rdy[r] = 0;
  endtask

  task automatic m_route(input slot_t s);
    if (s.pipe) begin x_ov = 1'b1; x_ort = s.rt; x_opl = s.pl; end
    else        begin x_ev = 1'b1; x_ert = s.rt; x_epl = s.pl; end
  endtask

  task automatic m_predict(input bit bt);
    m_iss0 = 1'b0; m_iss1 = 1'b0;
    x_ev = 1'b0; x_ov = 1'b0; x_ert = '0; x_ort = '0; x_epl = '0; x_opl = '0;
    if (!bt && mq.size() > 0) begin
      m_iss0 = m_can_go(mq[0]);
      if (mq.size() == 2 && m_iss0)
        m_iss1 = (mq[1].pipe != mq[0].pipe) && !(mq[0].wr && m_uses(mq[1], mq[0].rt)) &&
                 m_can_go(mq[1]);
    end
    m_ready = !bt && (mq.size() == 0 || (mq.size() == 1 && m_iss0) || m_iss1);
    if (m_iss0) m_route(mq[0]);
    if (m_iss1) m_route(mq[1]);
  endtask

  task automatic m_edge(input bit iv, input bit bt, input slot_t a, input slot_t b);
    if (m_iss0 && mq[0].wr) rdy[mq[0].rt] = now + int'(mq[0].lat);
    if (m_iss1 && mq[1].wr) rdy[mq[1].rt] = now + int'(mq[1].lat);
    if (mq.size() > 0 && !m_iss0 && !m_iss1 && !bt && m_stall < 65535) m_stall++;
    if (bt) mq.delete();
    else if (m_iss1) mq.delete();
    else if (m_iss0) void'(mq.pop_front());
    if (iv && m_ready) begin
      if (a.vld) mq.push_back(a);
      if (b.vld) mq.push_back(b);
    end
    now++;
  endtask

  function automatic bit [6:0] rnd_reg();
    if ($urandom_range(0, 15) == 0) return 7'd127;
    return 7'($urandom_range(0, 7));
  endfunction

  function automatic slot_t rnd_slot();
    slot_t s;
    s.vld = ($urandom_range(0, 7) != 0);
    s.pipe = 1'($urandom_range(0, 1));
    s.rt = rnd_reg(); s.wr = ($urandom_range(0, 3) != 0);
    s.ra = rnd_reg(); s.rb = rnd_reg(); s.rc = rnd_reg();
    s.use_bits = 3'($urandom_range(0, 7));
    s.lat = 3'($urandom_range(1, 7));
    s.pl = $urandom();
    return s;
  endfunction

  // ---------------- test sequence ----------------
  vec_t vecs [12];

  initial begin
    slot_t a0, a1, b0, c0, d0, d1, e0, e1, f0, g0, h0, h1, j0, k0, l0, nn;
    slot_t rs0, rs1;
    bit    riv, rbt;

    nn = none();
    a0 = mk(1'b0, 7'd1, 1'b1, 3'd2, 7'd0, 3'b000);
    a1 = mk(1'b1, 7'd5, 1'b1, 3'd1, 7'd2, 3'b100);
    b0 = mk(1'b0, 7'd4, 1'b1, 3'd6, 7'd0, 3'b000);
    c0 = mk(1'b0, 7'd10, 1'b1, 3'd1, 7'd4, 3'b100);
    d0 = mk(1'b0, 7'd11, 1'b1, 3'd1, 7'd0, 3'b000);
    d1 = mk(1'b0, 7'd12, 1'b1, 3'd1, 7'd0, 3'b000);

    // Each row is one cycle: inputs, then the expected outputs before the edge.
    vecs[0]  = row(1'b1, a0, a1, 1'b1, 1'b0, 7'd0,  1'b0, 7'd0, 16'd0);
    vecs[1]  = row(1'b1, b0, nn, 1'b1, 1'b1, 7'd1,  1'b1, 7'd5, 16'd0);
    vecs[2]  = row(1'b1, c0, nn, 1'b1, 1'b1, 7'd4,  1'b0, 7'd0, 16'd0);
    vecs[3]  = row(1'b1, d0, d1, 1'b0, 1'b0, 7'd0,  1'b0, 7'd0, 16'd0);
    vecs[4]  = row(1'b1, d0, d1, 1'b0, 1'b0, 7'd0,  1'b0, 7'd0, 16'd1);
    vecs[5]  = row(1'b1, d0, d1, 1'b0, 1'b0, 7'd0,  1'b0, 7'd0, 16'd2);
    vecs[6]  = row(1'b1, d0, d1, 1'b0, 1'b0, 7'd0,  1'b0, 7'd0, 16'd3);
    vecs[7]  = row(1'b1, d0, d1, 1'b0, 1'b0, 7'd0,  1'b0, 7'd0, 16'd4);
    vecs[8]  = row(1'b1, d0, d1, 1'b1, 1'b1, 7'd10, 1'b0, 7'd0, 16'd5);
    vecs[9]  = row(1'b0, nn, nn, 1'b0, 1'b1, 7'd11, 1'b0, 7'd0, 16'd5);
    vecs[10] = row(1'b0, nn, nn, 1'b1, 1'b1, 7'd12, 1'b0, 7'd0, 16'd5);
    vecs[11] = row(1'b0, nn, nn, 1'b1, 1'b0, 7'd0,  1'b0, 7'd0, 16'd5);

    do_reset();
    @(negedge clock);
    expect_out("reset", 1'b1, 1'b0, 7'd0, 1'b0, 7'd0);
    check("reset.stall_cycles", stall_cycles, 16'd0);
    adv();

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].iv, vecs[i].bt, vecs[i].s0, vecs[i].s1);
      expect_out($sformatf("row%0d", i), vecs[i].rdy, vecs[i].ev, vecs[i].ert,
                 vecs[i].ov, vecs[i].ort);
      check($sformatf("row%0d.stall_cycles", i), stall_cycles, vecs[i].stall);
      adv();
    end

    // Intra-pair RAW: odd writer of r7 (lat 4), even reader of r7 issues 4 cycles later.
    e0 = mk(1'b1, 7'd7, 1'b1, 3'd4, 7'd0, 3'b000);
    e1 = mk(1'b0, 7'd13, 1'b1, 3'd1, 7'd7, 3'b100);
    step(1'b1, 1'b0, e0, e1); expect_out("raw.c0", 1'b1, 1'b0, 7'd0, 1'b0, 7'd0); adv();
    step(1'b0, 1'b0, nn, nn); expect_out("raw.c1", 1'b0, 1'b0, 7'd0, 1'b1, 7'd7); adv();
    for (int c = 2; c <= 4; c++) begin
      step(1'b0, 1'b0, nn, nn);
      expect_out($sformatf("raw.c%0d", c), 1'b0, 1'b0, 7'd0, 1'b0, 7'd0);
      adv();
    end
    step(1'b0, 1'b0, nn, nn); expect_out("raw.c5", 1'b1, 1'b1, 7'd13, 1'b0, 7'd0);
    check("raw.stall_cycles", stall_cycles, 16'd8);
    adv();

    // WAW: r9 lat 6 in flight; a lat-2 write of r9 waits until the entry reaches 1.
    f0 = mk(1'b0, 7'd9, 1'b1, 3'd6, 7'd0, 3'b000);
    g0 = mk(1'b1, 7'd9, 1'b1, 3'd2, 7'd0, 3'b000);
    step(1'b1, 1'b0, f0, nn); expect_out("waw.c0", 1'b1, 1'b0, 7'd0, 1'b0, 7'd0); adv();
    step(1'b1, 1'b0, g0, nn); expect_out("waw.c1", 1'b1, 1'b1, 7'd9, 1'b0, 7'd0); adv();
    for (int c = 2; c <= 5; c++) begin
      step(1'b0, 1'b0, nn, nn);
      expect_out($sformatf("waw.c%0d", c), 1'b0, 1'b0, 7'd0, 1'b0, 7'd0);
      adv();
    end
    step(1'b0, 1'b0, nn, nn); expect_out("waw.c6", 1'b1, 1'b0, 7'd0, 1'b1, 7'd9);
    check("waw.stall_cycles", stall_cycles, 16'd12);
    adv();

    // Flush while slot 1 is held. The scoreboard must keep counting through the flush.
    h0 = mk(1'b0, 7'd20, 1'b1, 3'd5, 7'd0, 3'b000);
    h1 = mk(1'b0, 7'd21, 1'b1, 3'd1, 7'd20, 3'b100);
    j0 = mk(1'b1, 7'd22, 1'b1, 3'd1, 7'd20, 3'b100);
    step(1'b1, 1'b0, h0, h1); expect_out("br.c0", 1'b1, 1'b0, 7'd0, 1'b0, 7'd0); adv();
    step(1'b0, 1'b0, nn, nn); expect_out("br.c1", 1'b0, 1'b1, 7'd20, 1'b0, 7'd0); adv();
    step(1'b1, 1'b1, j0, nn); expect_out("br.c2", 1'b0, 1'b0, 7'd0, 1'b0, 7'd0); adv();
    step(1'b1, 1'b0, j0, nn); expect_out("br.c3", 1'b1, 1'b0, 7'd0, 1'b0, 7'd0);
    check("br.stall_after_flush", stall_cycles, 16'd12);
    adv();
    step(1'b0, 1'b0, nn, nn); expect_out("br.c4", 1'b0, 1'b0, 7'd0, 1'b0, 7'd0); adv();
    step(1'b0, 1'b0, nn, nn); expect_out("br.c5", 1'b0, 1'b0, 7'd0, 1'b0, 7'd0); adv();
    step(1'b0, 1'b0, nn, nn); expect_out("br.c6", 1'b1, 1'b0, 7'd0, 1'b1, 7'd22);
    check("br.stall_cycles", stall_cycles, 16'd14);
    adv();

    // Reset in the middle of a stall, with a flush and an offered pair present.
    k0 = mk(1'b0, 7'd30, 1'b1, 3'd7, 7'd0, 3'b000);
    l0 = mk(1'b1, 7'd31, 1'b1, 3'd1, 7'd30, 3'b100);
    step(1'b1, 1'b0, k0, nn); expect_out("rst.c0", 1'b1, 1'b0, 7'd0, 1'b0, 7'd0); adv();
    step(1'b1, 1'b0, l0, nn); expect_out("rst.c1", 1'b1, 1'b1, 7'd30, 1'b0, 7'd0); adv();
    step(1'b0, 1'b0, nn, nn); expect_out("rst.c2", 1'b0, 1'b0, 7'd0, 1'b0, 7'd0); adv();
    step(1'b1, 1'b1, l0, nn);
    check("rst.stall_before", stall_cycles, 16'd15);
    reset = 1'b0;
    adv();
    reset = 1'b1;
    step(1'b0, 1'b0, nn, nn);
    expect_out("rst.after", 1'b1, 1'b0, 7'd0, 1'b0, 7'd0);
    check("rst.stall_cycles", stall_cycles, 16'd0);
    adv();
    step(1'b1, 1'b0, l0, nn); expect_out("rst.c4", 1'b1, 1'b0, 7'd0, 1'b0, 7'd0); adv();
    step(1'b0, 1'b0, nn, nn); expect_out("rst.c5", 1'b1, 1'b0, 7'd0, 1'b1, 7'd31); adv();

    // Randomized run against the reference model.
    do_reset();
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      rs0 = rnd_slot();
      rs1 = rnd_slot();
      riv = ($urandom_range(0, 3) != 0);
      rbt = ($urandom_range(0, 19) == 0);
      step(riv, rbt, rs0, rs1);
      m_predict(rbt);
      check("rnd.in_ready", in_ready, m_ready);
      check("rnd.ep_valid", ep_valid, x_ev);
      check("rnd.ep_rt", ep_rt, x_ert);
      check("rnd.ep_pl", ep_pl, x_epl);
      check("rnd.op_valid", op_valid, x_ov);
      check("rnd.op_rt", op_rt, x_ort);
      check("rnd.op_pl", op_pl, x_opl);
      check("rnd.stall_cycles", stall_cycles, 16'(m_stall));
      adv();
      m_edge(riv, rbt, rs0, rs1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_issue_scheduler.md
# dual_issue_scheduler

Dual-issue scheduler between decode and the even/odd execution pipes of the SPU-lite core. Accepts one decoded instruction pair per handshake and routes each slot to its pipe (even or odd). Holds slots back on structural hazards, RAW/WAW hazards and in-order constraints, using a 128-entry latency scoreboard matched to the forwarding network. A taken branch flushes the pending pair.

## Interface
Parameters:
- PW, 32, opaque per-slot payload width (opcode + immediates), passed through unchanged
- LW, 3, latency field width; legal latencies 1..7

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low; sampled on clock rising edge
- in_valid  in  1  decode presents a pair
- in_ready  out  1  scheduler accepts the pair at this edge
- sN_vld  in  1  slot N (N=0 older, N=1 younger) holds a real instruction
- sN_pipe  in  1  0 = even pipe, 1 = odd pipe
- sN_rt  in  7  destination register
- sN_wr  in  1  slot writes sN_rt
- sN_ra, sN_rb, sN_rc  in  7 each  source registers
- sN_use  in  3  source-use bits {ra, rb, rc}
- sN_lat  in  LW  cycles until result is forwardable
- sN_pl  in  PW  payload
- branch_taken  in  1  flush request from the branch unit
- ep_valid / op_valid  out  1  issue strobe, even / odd pipe
- ep_pl / op_pl  out  PW  issued payload
- ep_rt / op_rt  out  7  issued destination
- stall_cycles  out  16  saturating count of stall cycles

## Operation
- Pair buffer (two slots + per-slot pending bit); states: EMPTY (no pending), PAIR (both pending), SECOND (slot 1 only pending).
- Accept at an edge when in_valid && in_ready. Slot pending = sN_vld. A pair with both sN_vld=0 is accepted and leaves the buffer EMPTY.
- Scoreboard: 128 × LW counters, each = cycles remaining before that register is forwardable.
  - Every edge: nonzero entries decrement.
  - An issued writer with wr=1 loads lat-1 into its rt entry. The load overrides the decrement.
  - Slot 0 and slot 1 never issue the same rt in one cycle.
- Slot issue conditions, all evaluated combinationally from the buffer:
  - RAW: every used source has scoreboard entry 0.
  - WAW: if wr=1, entry(rt) ≤ lat-1, so writes complete in order.
  - Slot 1 requires slot 0 issued earlier or issuing this cycle.
  - Slot 1 is held when slot 0 is still pending at cycle start and either targets the same pipe, or has wr=1 and slot 1 reads or writes slot 0's rt.
- Issued slot drives its pipe's valid/pl/rt. The pending bit clears at the edge.
- in_ready = (state==EMPTY) || (every pending slot issues this cycle), gated by !branch_taken.
- branch_taken: no issue this cycle, buffer clears at the edge, in_ready=0. Scoreboard keeps counting, because in-flight results still retire.
- stall_cycles increments (saturating at 0xFFFF) on each edge where state≠EMPTY, nothing issues, and branch_taken=0.

## Timing
- Reset (reset=0 at an edge):
  - state EMPTY; scoreboard all 0; stall_cycles 0.
  - ep_valid = op_valid = 0; ep_pl, op_pl, ep_rt, op_rt = 0.
  - in_ready = 1 the cycle after reset deasserts.
  - Reset overrides branch_taken and an in-progress accept.
- Issue latency: a pair accepted at edge E can issue in the cycle after E. Issue outputs are combinational from the registered buffer.
- Throughput: one pair per cycle with no hazards; a new pair is accepted at the same edge the last pending slot issues.
- Dependents: writer issued in cycle C with lat L → dependent issues no earlier than cycle C+L. L=1 gives back-to-back issue.
- Pair targeting one pipe: slot 0 issues in cycle C, slot 1 in C+1 at earliest.
- Accept and flush in the same cycle cannot occur, because in_ready is low during branch_taken.

## Test plan
- Reset, then pair {s0: even, rt=1, lat=2; s1: odd, rt=5, ra=2, use=100} → both issue in the cycle after accept; next pair accepted at the same edge.
- s0 even writes r4 with lat=6; next pair s0 reads r4 → that slot stalls 5 cycles and issues 6 cycles after r4 issued; stall_cycles = 5.
- Pair with both slots even, independent → slot 0 issues in cycle C, slot 1 in C+1; in_ready=0 in C and 1 in C+1.
- Intra-pair RAW: s0 odd writes r7 with lat=4; s1 even reads r7 → s1 issues 4 cycles after s0.
- WAW: r9 lat=6 issued; next slot writes r9 with lat=2 → held until entry ≤ 1, then issues.
- branch_taken while slot 1 is held → no issue that cycle, buffer EMPTY at next edge, scoreboard entries keep decrementing; reset=0 mid-stall → all outputs 0 and stall_cycles=0.
